// File: rtl/tdc_thermo_encoder.sv
// Carry-chain TDC back end: re-registers the tap word, detects a rising edge on tap 0,
// encodes a bubble-tolerant fine count and emits coarse/fine timestamps on valid/ready.
module tdc_thermo_encoder #(
  parameter int TAPS = 64,
  parameter int CW   = 16,
  parameter int FW   = $clog2(TAPS + 1),
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [TAPS-1:0] taps_in,
  output logic            ts_valid,
  input  logic            ts_ready,
  output logic [CW-1:0]   ts_coarse,
  output logic [FW-1:0]   ts_fine,
  output logic [DW-1:0]   drop_cnt
);

  // Ones count rather than a first-zero search, so isolated bubbles only cost their own bit.
  function automatic logic [FW-1:0] popcount(input logic [TAPS-1:0] w);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) begin
      n = n + FW'(w[i]);
    end
    return n;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TAPS-1:0] s1_q, s1_d;
  logic            s1_vld_q, s1_vld_d;
  logic            prev_tap0_q, prev_tap0_d;
  logic [CW-1:0]   c1_q, c1_d;
  logic            v2_q, v2_d;
  logic [FW-1:0]   f2_q, f2_d;
  logic [CW-1:0]   c2_q, c2_d;
  logic            ts_valid_q, ts_valid_d;
  logic [CW-1:0]   ts_coarse_q, ts_coarse_d;
  logic [FW-1:0]   ts_fine_q, ts_fine_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            hit;
  logic            out_free;

  always_comb begin
    cnt_d       = enable ? cnt_q + CW'(1) : '0;
    s1_d        = taps_in;
    c1_d        = cnt_q;
    s1_vld_d    = 1'b1;
    // prev_tap0 keeps its reset value of 1 until s1 holds a real sample, so a tap 0 that
    // is already high when reset releases never looks like a rising edge.
    prev_tap0_d = s1_vld_q ? s1_q[0] : prev_tap0_q;

    hit  = s1_q[0] & ~prev_tap0_q & enable;
    v2_d = hit;
    f2_d = popcount(s1_q);
    c2_d = c1_q;

    out_free    = ~ts_valid_q | ts_ready;
    ts_valid_d  = ts_valid_q;
    ts_coarse_d = ts_coarse_q;
    ts_fine_d   = ts_fine_q;
    drop_cnt_d  = drop_cnt_q;

    if (v2_q && out_free) begin
      ts_valid_d  = 1'b1;
      ts_coarse_d = c2_q;
      ts_fine_d   = f2_q;
    end else if (ts_valid_q && ts_ready) begin
      ts_valid_d = 1'b0;
    end

    if (v2_q && !out_free && (drop_cnt_q != {DW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_q        <= '0;
      s1_vld_q    <= 1'b0;
      prev_tap0_q <= 1'b1;
      c1_q        <= '0;
      v2_q        <= 1'b0;
      f2_q        <= '0;
      c2_q        <= '0;
      ts_valid_q  <= 1'b0;
      ts_coarse_q <= '0;
      ts_fine_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s1_vld_q    <= s1_vld_d;
      prev_tap0_q <= prev_tap0_d;
      c1_q        <= c1_d;
      v2_q        <= v2_d;
      f2_q        <= f2_d;
      c2_q        <= c2_d;
      ts_valid_q  <= ts_valid_d;
      ts_coarse_q <= ts_coarse_d;
      ts_fine_q   <= ts_fine_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign ts_valid  = ts_valid_q;
  assign ts_coarse = ts_coarse_q;
  assign ts_fine   = ts_fine_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Directed bench for tdc_thermo_encoder: scoreboard of expected timestamps popped on each transfer.
module tb_tdc_thermo_encoder;

  localparam int TAPS = 64;
  localparam int CW   = 16;
  localparam int FW   = 7;
  localparam int DW   = 8;
  localparam int CW4  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [TAPS-1:0] taps_in = '0;
  logic            ts_valid;
  logic            ts_ready = 1'b1;
  logic [CW-1:0]   ts_coarse;
  logic [FW-1:0]   ts_fine;
  logic [DW-1:0]   drop_cnt;

  logic            en4 = 1'b1;
  logic [TAPS-1:0] taps4 = '0;
  logic            ts_valid4;
  logic [CW4-1:0]  ts_coarse4;
  logic [FW-1:0]   ts_fine4;
  logic [DW-1:0]   drop_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0]  model_cnt;
  logic [CW4-1:0] model_cnt4;
  logic [CW+FW-1:0] sb[$];

  always #5 clk = ~clk;

  tdc_thermo_encoder #(.TAPS(TAPS), .CW(CW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .taps_in(taps_in),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
    .ts_fine(ts_fine), .drop_cnt(drop_cnt)
  );

  tdc_thermo_encoder #(.TAPS(TAPS), .CW(CW4), .DW(DW)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .taps_in(taps4),
    .ts_valid(ts_valid4), .ts_ready(1'b1), .ts_coarse(ts_coarse4),
    .ts_fine(ts_fine4), .drop_cnt(drop_cnt4)
  );

  // Coarse counter reference: value present at the edge that samples a freshly driven tap word.
  always @(posedge clk) begin
    if (rst) model_cnt <= '0;
    else if (enable) model_cnt <= model_cnt + CW'(1);
    else model_cnt <= '0;
    if (rst) model_cnt4 <= '0;
    else if (en4) model_cnt4 <= model_cnt4 + CW4'(1);
    else model_cnt4 <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ts_valid && ts_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL unexpected_ts observed=%0h expected=none", {ts_coarse, ts_fine});
      end else begin
        chk("ts", 32'({ts_coarse, ts_fine}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [TAPS-1:0] w, input bit push, input int fine);
    if (push) sb.push_back({model_cnt, FW'(fine)});
    taps_in = w;
    step();
    taps_in = '0;
    step();
  endtask

  task automatic wait_cnt(input logic [CW-1:0] v);
    int g = 0;
    while (model_cnt != v && g < 300) begin
      step();
      g++;
    end
    if (model_cnt != v) chk("wait_cnt_timeout", 32'(model_cnt), 32'(v));
  endtask

  task automatic wait_cnt4(input logic [CW4-1:0] v);
    int g = 0;
    while (model_cnt4 != v && g < 40) begin
      step();
      g++;
    end
    if (model_cnt4 != v) chk("wait_cnt4_timeout", 32'(model_cnt4), 32'(v));
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 32'(ts_valid), 0);
    chk("rst_coarse", 32'(ts_coarse), 0);
    chk("rst_fine", 32'(ts_fine), 0);
    chk("rst_drop", 32'(drop_cnt), 0);

    // single hit at cnt 10, latency check
    wait_cnt(16'd10);
    sb.push_back({16'd10, 7'd5});
    taps_in = 64'h0000_0000_0000_001F;
    step();
    taps_in = '0;
    step();
    chk("lat_early", 32'(ts_valid), 0);
    step();
    chk("lat_n2", 32'(ts_valid), 1);
    step();
    step();
    chk("single_ts", 32'(sb.size()), 0);

    // bubble and full scale
    pulse(64'h0000_0000_0000_00FB, 1, 7);
    pulse({TAPS{1'b1}}, 1, 64);
    pulse(64'h0000_0000_0000_0001, 1, 1);
    repeat (4) step();
    chk("bubble_drain", 32'(sb.size()), 0);

    // stall: A held, B dropped
    do_reset();
    ts_ready = 1'b0;
    wait_cnt(16'd20);
    pulse(64'h3, 1, 2);
    wait_cnt(16'd30);
    pulse(64'h3, 0, 0);
    repeat (4) step();
    chk("hold_valid", 32'(ts_valid), 1);
    chk("hold_coarse", 32'(ts_coarse), 20);
    chk("hold_fine", 32'(ts_fine), 2);
    chk("drop_one", 32'(drop_cnt), 1);
    ts_ready = 1'b1;
    step();
    chk("xfer_valid_low", 32'(ts_valid), 0);
    chk("xfer_sb", 32'(sb.size()), 0);

    // tap 0 held high: exactly one timestamp
    sb.push_back({model_cnt, 7'd1});
    taps_in = 64'h1;
    repeat (50) step();
    taps_in = '0;
    repeat (5) step();
    chk("held_one", 32'(sb.size()), 0);

    // back-to-back: second timestamp loads on the edge that transfers the first
    ts_ready = 1'b0;
    sb.push_back({model_cnt, 7'd1});
    taps_in = 64'h1;
    step();
    taps_in = '0;
    step();
    sb.push_back({model_cnt, 7'd1});
    taps_in = 64'h1;
    step();
    taps_in = '0;
    step();
    chk("b2b_hold", 32'(ts_valid), 1);
    ts_ready = 1'b1;
    step();
    chk("b2b_stay", 32'(ts_valid), 1);
    step();
    chk("b2b_end", 32'(ts_valid), 0);
    chk("b2b_sb", 32'(sb.size()), 0);

    // drop saturation, then reset mid-operation with tap 0 high
    ts_ready = 1'b0;
    for (int i = 0; i < 300; i++) pulse(64'h1, 0, 0);
    repeat (4) step();
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("sat_valid", 32'(ts_valid), 1);
    rst = 1'b1;
    taps_in = 64'h1;
    ts_ready = 1'b1;
    step();
    chk("midrst_valid", 32'(ts_valid), 0);
    chk("midrst_drop", 32'(drop_cnt), 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    taps_in = '0;
    repeat (4) step();
    chk("no_spurious", 32'(ts_valid), 0);
    chk("no_spurious_sb", 32'(sb.size()), 0);

    // disabled: hits ignored, counter restarts from 0
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse(64'h7, 0, 0);
    repeat (3) step();
    chk("dis_valid", 32'(ts_valid), 0);
    sb.push_back({16'd0, 7'd1});
    enable = 1'b1;
    taps_in = 64'h1;
    step();
    taps_in = '0;
    repeat (4) step();
    chk("reenable_sb", 32'(sb.size()), 0);

    // 4-bit coarse counter wraps
    do_reset();
    wait_cnt4(4'd15);
    taps4 = 64'h1;
    step();
    taps4 = '0;
    step();
    step();
    chk("wrap15_valid", 32'(ts_valid4), 1);
    chk("wrap15_coarse", 32'(ts_coarse4), 15);
    wait_cnt4(4'd0);
    taps4 = 64'h3;
    step();
    taps4 = '0;
    step();
    step();
    chk("wrap0_valid", 32'(ts_valid4), 1);
    chk("wrap0_coarse", 32'(ts_coarse4), 0);
    chk("wrap0_fine", 32'(ts_fine4), 2);

    repeat (3) step();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
